// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared types and constants for the LED frame decoder
package led_pkg;

    localparam int ROWS = 16;
    localparam int COLS = 8;

    localparam int COL_MSB  = 9;
    localparam int COL_LSB  = 8;
    localparam int RSVD_BIT = 7;
    localparam int Y_MSB    = 6;
    localparam int Y_LSB    = 3;
    localparam int X_MSB    = 2;
    localparam int X_LSB    = 0;

    typedef enum logic [1:0] {
        COL_BLANK = 2'b00,
        COL_GRN   = 2'b01,
        COL_RED   = 2'b10,
        COL_BOTH  = 2'b11
    } colour_t;

    typedef struct packed {
        colour_t    col;
        logic       rsvd;
        logic [3:0] y;
        logic [2:0] x;
    } pix_word_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/led_fb_bank.sv
// rtl/led_fb_bank.sv - one 16x8 two-colour frame buffer with OR-write, clear and row read
module led_fb_bank
    import led_pkg::*;
(
    input  logic            CLK,
    input  logic            RST,
    input  logic            clr,
    input  logic            wr,
    input  logic [3:0]      wr_y,
    input  logic [2:0]      wr_x,
    input  colour_t         wr_col,
    input  logic [3:0]      rd_y,
    output logic [COLS-1:0] rd_red,
    output logic [COLS-1:0] rd_grn
);

    logic [COLS-1:0] red [ROWS];
    logic [COLS-1:0] grn [ROWS];
    logic [COLS-1:0] xmask;
    logic            set_red;
    logic            set_grn;

    assign xmask   = {{(COLS-1){1'b0}}, 1'b1} << wr_x;
    assign set_red = (wr_col == COL_RED) || (wr_col == COL_BOTH);
    assign set_grn = (wr_col == COL_GRN) || (wr_col == COL_BOTH);

    // Clear and write may land in the same cycle: the write survives the clear.
    always_ff @(posedge CLK) begin
        for (int r = 0; r < ROWS; r++) begin
            if (RST) begin
                red[r] <= '0;
                grn[r] <= '0;
            end else begin
                red[r] <= (clr ? '0 : red[r]) |
                          ((wr && set_red && (wr_y == 4'(r))) ? xmask : '0);
                grn[r] <= (clr ? '0 : grn[r]) |
                          ((wr && set_grn && (wr_y == 4'(r))) ? xmask : '0);
            end
        end
    end

    assign rd_red = red[rd_y];
    assign rd_grn = grn[rd_y];

endmodule

// File: rtl/led_frame_decoder.sv
// rtl/led_frame_decoder.sv - double-buffered LED pixel-word decoder; ball tracker under LED_FRAME_DECODER_BALL_TRACK_EN
module led_frame_decoder
    import led_pkg::*;
#(
    parameter logic [15:0] TIMEOUT = 16'd50000,
    parameter int          CNT_W   = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [9:0]       LEDIN,
    input  logic             STB,
    input  logic             FRAME,
    input  logic [3:0]       ROWSEL,
    output logic [7:0]       ROWRED,
    output logic [7:0]       ROWGRN,
    output logic [CNT_W-1:0] FRAMES,
    output logic [6:0]       PIXCNT,
    output logic             ERR,
    output logic             TMO,
    output logic [2:0]       BALLX,
    output logic [3:0]       BALLY,
    output logic             BALLV
);

    pix_word_t  word;
    state_t     state;
    state_t     state_nx;
    logic       active;
    logic       tmo_run;
    logic [15:0] tmo_cnt;
    logic       tmo_hit;
    logic       swap;
    logic       accept;
    logic       rsvd_err;
    logic       role;
    logic       back_sel;
    logic [6:0] live;
    logic [7:0] bank_red [2];
    logic [7:0] bank_grn [2];

    assign word = '{col:  colour_t'(LEDIN[COL_MSB:COL_LSB]),
                    rsvd: LEDIN[RSVD_BIT],
                    y:    LEDIN[Y_MSB:Y_LSB],
                    x:    LEDIN[X_MSB:X_LSB]};

    always_ff @(posedge CLK) begin
        if (RST) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (state == ST_IDLE && FRAME) state_nx = ST_RUN;
    end

    // The first FRAME already counts as seen, so its coincident word is kept.
    always_comb begin
        active  = (state == ST_RUN) || FRAME;
        tmo_run = (state == ST_RUN);
    end

    assign tmo_hit  = tmo_run && (tmo_cnt == TIMEOUT - 16'd1);
    assign swap     = FRAME || tmo_hit;
    assign accept   = active && STB && !word.rsvd && (word.col != COL_BLANK);
    assign rsvd_err = active && STB && word.rsvd;
    assign back_sel = role ^ swap;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        led_fb_bank u_bank (
            .CLK    (CLK),
            .RST    (RST),
            .clr    (swap && (back_sel == 1'(b))),
            .wr     (accept && (back_sel == 1'(b))),
            .wr_y   (word.y),
            .wr_x   (word.x),
            .wr_col (word.col),
            .rd_y   (ROWSEL),
            .rd_red (bank_red[b]),
            .rd_grn (bank_grn[b])
        );
    end

    // The front bank after this cycle is the one not being written.
    always_ff @(posedge CLK) begin
        if (RST) begin
            role    <= 1'b0;
            FRAMES  <= '0;
            PIXCNT  <= '0;
            live    <= '0;
            ERR     <= 1'b0;
            TMO     <= 1'b0;
            tmo_cnt <= '0;
            ROWRED  <= '0;
            ROWGRN  <= '0;
        end else begin
            ROWRED <= back_sel ? bank_red[0] : bank_red[1];
            ROWGRN <= back_sel ? bank_grn[0] : bank_grn[1];
            if (rsvd_err)         ERR <= 1'b1;
            if (tmo_hit && !FRAME) TMO <= 1'b1;
            if (swap) begin
                role    <= ~role;
                FRAMES  <= FRAMES + CNT_W'(1);
                PIXCNT  <= live;
                live    <= accept ? 7'd1 : 7'd0;
                tmo_cnt <= '0;
            end else begin
                if (accept && live != 7'd127) live <= live + 7'd1;
                tmo_cnt <= tmo_run ? tmo_cnt + 16'd1 : 16'd0;
            end
        end
    end

`ifdef LED_FRAME_DECODER_BALL_TRACK_EN
    logic [2:0] trk_x;
    logic [3:0] trk_y;
    logic       trk_v;
    logic       trk_hit;

    assign trk_hit = accept && (word.col == COL_GRN);

    always_ff @(posedge CLK) begin
        if (RST) begin
            trk_x <= '0;
            trk_y <= '0;
            trk_v <= 1'b0;
            BALLX <= '0;
            BALLY <= '0;
            BALLV <= 1'b0;
        end else if (swap) begin
            BALLX <= trk_x;
            BALLY <= trk_y;
            BALLV <= trk_v;
            trk_x <= trk_hit ? word.x : 3'd0;
            trk_y <= trk_hit ? word.y : 4'd0;
            trk_v <= trk_hit;
        end else if (trk_hit) begin
            trk_x <= word.x;
            trk_y <= word.y;
            trk_v <= 1'b1;
        end
    end
`else
    assign BALLX = '0;
    assign BALLY = '0;
    assign BALLV = 1'b0;
`endif

endmodule

// File: tb/tb_led_frame_decoder.sv
// tb/tb_led_frame_decoder.sv - directed table-driven bench for led_frame_decoder
module tb_led_frame_decoder;

`ifdef LED_FRAME_DECODER_BALL_TRACK_EN
    localparam bit TRK = 1'b1;
`else
    localparam bit TRK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       stb = 1'b0;
    logic       frame = 1'b0;
    logic [9:0] ledin = '0;
    logic [3:0] rowsel = '0;

    logic [7:0] rowred, rowgrn, frames, t_rowred, t_rowgrn, t_frames;
    logic [6:0] pixcnt, t_pixcnt;
    logic       err, tmo, ballv, t_err, t_tmo, t_ballv;
    logic [2:0] ballx, t_ballx;
    logic [3:0] bally, t_bally;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    led_frame_decoder dut (
        .CLK(clk), .RST(rst), .LEDIN(ledin), .STB(stb), .FRAME(frame), .ROWSEL(rowsel),
        .ROWRED(rowred), .ROWGRN(rowgrn), .FRAMES(frames), .PIXCNT(pixcnt),
        .ERR(err), .TMO(tmo), .BALLX(ballx), .BALLY(bally), .BALLV(ballv)
    );

    led_frame_decoder #(.TIMEOUT(16'd16), .CNT_W(8)) dut_t (
        .CLK(clk), .RST(rst), .LEDIN(ledin), .STB(stb), .FRAME(frame), .ROWSEL(rowsel),
        .ROWRED(t_rowred), .ROWGRN(t_rowgrn), .FRAMES(t_frames), .PIXCNT(t_pixcnt),
        .ERR(t_err), .TMO(t_tmo), .BALLX(t_ballx), .BALLY(t_bally), .BALLV(t_ballv)
    );

    typedef struct {
        logic       r, f, s;
        logic [9:0] l;
        logic [3:0] rs;
        bit         chk_row;
        logic [7:0] red, grn, frm;
        logic [6:0] pix;
        logic       er, tm;
        logic [2:0] bx;
        logic [3:0] by;
        logic       bv;
    } vec_t;

    function automatic logic [9:0] w(input logic [1:0] c, input logic rv,
                                     input logic [3:0] y, input logic [2:0] x);
        return {c, rv, y, x};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic f, input logic s,
                        input logic [9:0] l, input logic [3:0] rs);
        rst = r; frame = f; stb = s; ledin = l; rowsel = rs;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 10'd0, rowsel);
    endtask

    vec_t tbl [15];

    initial begin
        tbl[0]  = '{1, 0, 0, 10'd0, 4'd0, 1, 8'h00, 8'h00, 8'd0, 7'd0, 0, 0, 3'd0, 4'd0, 0};
        tbl[1]  = '{0, 1, 0, 10'd0, 4'd0, 0, 8'h00, 8'h00, 8'd1, 7'd0, 0, 0, 3'd0, 4'd0, 0};
        tbl[2]  = '{0, 0, 1, w(2'b10, 0, 4'd12, 3'd0), 4'd0, 0, 8'h00, 8'h00, 8'd1, 7'd0, 0, 0, 3'd0, 4'd0, 0};
        tbl[3]  = '{0, 0, 1, w(2'b10, 0, 4'd12, 3'd1), 4'd0, 0, 8'h00, 8'h00, 8'd1, 7'd0, 0, 0, 3'd0, 4'd0, 0};
        tbl[4]  = '{0, 0, 1, w(2'b10, 0, 4'd12, 3'd2), 4'd0, 0, 8'h00, 8'h00, 8'd1, 7'd0, 0, 0, 3'd0, 4'd0, 0};
        tbl[5]  = '{0, 1, 0, 10'd0, 4'd12, 0, 8'h00, 8'h00, 8'd2, 7'd3, 0, 0, 3'd0, 4'd0, 0};
        tbl[6]  = '{0, 0, 0, 10'd0, 4'd12, 1, 8'h07, 8'h00, 8'd2, 7'd3, 0, 0, 3'd0, 4'd0, 0};
        tbl[7]  = '{0, 0, 1, w(2'b01, 0, 4'd5, 3'd3), 4'd12, 1, 8'h07, 8'h00, 8'd2, 7'd3, 0, 0, 3'd0, 4'd0, 0};
        tbl[8]  = '{0, 0, 1, w(2'b10, 1, 4'd0, 3'd0), 4'd12, 1, 8'h07, 8'h00, 8'd2, 7'd3, 1, 0, 3'd0, 4'd0, 0};
        tbl[9]  = '{0, 1, 0, 10'd0, 4'd5, 0, 8'h00, 8'h00, 8'd3, 7'd1, 1, 0,
                    TRK ? 3'd3 : 3'd0, TRK ? 4'd5 : 4'd0, TRK};
        tbl[10] = '{0, 0, 0, 10'd0, 4'd5, 1, 8'h00, 8'h08, 8'd3, 7'd1, 1, 0,
                    TRK ? 3'd3 : 3'd0, TRK ? 4'd5 : 4'd0, TRK};
        tbl[11] = '{0, 0, 0, 10'd0, 4'd0, 1, 8'h00, 8'h00, 8'd3, 7'd1, 1, 0,
                    TRK ? 3'd3 : 3'd0, TRK ? 4'd5 : 4'd0, TRK};
        tbl[12] = '{0, 1, 1, w(2'b11, 0, 4'd0, 3'd7), 4'd0, 0, 8'h00, 8'h00, 8'd4, 7'd0, 1, 0, 3'd0, 4'd0, 0};
        tbl[13] = '{0, 1, 0, 10'd0, 4'd0, 0, 8'h00, 8'h00, 8'd5, 7'd1, 1, 0, 3'd0, 4'd0, 0};
        tbl[14] = '{0, 0, 0, 10'd0, 4'd0, 1, 8'h80, 8'h80, 8'd5, 7'd1, 1, 0, 3'd0, 4'd0, 0};

        for (int k = 0; k < 15; k++) begin
            step(tbl[k].r, tbl[k].f, tbl[k].s, tbl[k].l, tbl[k].rs);
            chk($sformatf("v%0d frames", k), 32'(frames), 32'(tbl[k].frm));
            chk($sformatf("v%0d pixcnt", k), 32'(pixcnt), 32'(tbl[k].pix));
            chk($sformatf("v%0d err", k), 32'(err), 32'(tbl[k].er));
            chk($sformatf("v%0d tmo", k), 32'(tmo), 32'(tbl[k].tm));
            chk($sformatf("v%0d ball", k), {24'd0, ballv, bally, ballx},
                {24'd0, tbl[k].bv, tbl[k].by, tbl[k].bx});
            if (tbl[k].chk_row) begin
                chk($sformatf("v%0d rowred", k), 32'(rowred), 32'(tbl[k].red));
                chk($sformatf("v%0d rowgrn", k), 32'(rowgrn), 32'(tbl[k].grn));
            end
        end

        // Saturation: 200 accepted words, the last one green at (7,7).
        for (int i = 0; i < 200; i++)
            step(1'b0, 1'b0, 1'b1,
                 w((i == 199) ? 2'b01 : 2'b10, 1'b0, 4'(i % 16), 3'(i % 8)), 4'd0);
        step(1'b0, 1'b1, 1'b0, 10'd0, 4'd0);
        chk("sat pixcnt", 32'(pixcnt), 32'd127);
        chk("sat frames", 32'(frames), 32'd6);
        chk("sat ball", {24'd0, ballv, bally, ballx},
            TRK ? {24'd0, 1'b1, 4'd7, 3'd7} : 32'd0);

        // Reset mid-frame clears everything.
        step(1'b0, 1'b0, 1'b1, w(2'b01, 1'b0, 4'd0, 3'd0), 4'd0);
        step(1'b0, 1'b0, 1'b1, w(2'b10, 1'b1, 4'd0, 3'd0), 4'd0);
        step(1'b1, 1'b0, 1'b0, 10'd0, 4'd0);
        chk("rst all", {rowred, rowgrn, frames, pixcnt, err},
            32'd0);
        chk("rst tmo ball", {27'd0, tmo, ballv, 3'(bally), ballx[1:0]} | {29'd0, ballx}, 32'd0);

        // IDLE: words ignored and timeout stopped until the first FRAME.
        step(1'b0, 1'b0, 1'b1, w(2'b01, 1'b0, 4'd2, 3'd2), 4'd2);
        step(1'b0, 1'b0, 1'b1, w(2'b11, 1'b0, 4'd2, 3'd5), 4'd2);
        idle(20);
        chk("idle frames", 32'(frames), 32'd0);
        chk("idle t_frames", 32'(t_frames), 32'd0);
        step(1'b0, 1'b1, 1'b0, 10'd0, 4'd2);
        chk("idle first pixcnt", 32'(pixcnt), 32'd0);
        chk("idle first frames", 32'(frames), 32'd1);
        idle(1);
        chk("idle row2 grn", 32'(rowgrn), 32'd0);
        chk("idle row2 red", 32'(rowred), 32'd0);

        // Forced swaps every 16 cycles on the TIMEOUT=16 instance.
        step(1'b1, 1'b0, 1'b0, 10'd0, 4'd0);
        step(1'b0, 1'b1, 1'b0, 10'd0, 4'd0);
        chk("t first frames", 32'(t_frames), 32'd1);
        idle(15);
        chk("t before tmo frames", 32'(t_frames), 32'd1);
        chk("t before tmo", 32'(t_tmo), 32'd0);
        idle(1);
        chk("t tmo frames", 32'(t_frames), 32'd2);
        chk("t tmo", 32'(t_tmo), 32'd1);
        idle(16);
        chk("t second tmo frames", 32'(t_frames), 32'd3);

        // FRAME coinciding with the timeout is one swap and not a forced one.
        step(1'b1, 1'b0, 1'b0, 10'd0, 4'd0);
        step(1'b0, 1'b1, 1'b0, 10'd0, 4'd0);
        idle(15);
        step(1'b0, 1'b1, 1'b0, 10'd0, 4'd0);
        chk("coinc frames", 32'(t_frames), 32'd2);
        chk("coinc tmo", 32'(t_tmo), 32'd0);
        idle(1);
        chk("coinc frames after", 32'(t_frames), 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/led_frame_decoder.md
LED_FRAME_DECODER -- requirements
Module: led_frame_decoder

Interface
REQ-001 Parameter TIMEOUT, default 16'd50000, max cycles between frame swaps before a forced swap.
REQ-002 Parameter CNT_W, default 8, width of FRAMES counter.
REQ-003 CLK  in  1  system clock; all logic on posedge CLK.
REQ-004 RST  in  1  reset, synchronous, active-high.
REQ-005 LEDIN  in  10  multiplexed pixel word: [9:8] colour (00 blank, 01 green/ball, 10 red/bar, 11 both), [7] reserved 0, [6:3] y, [2:0] x.
REQ-006 STB  in  1  LEDIN valid this cycle.
REQ-007 FRAME  in  1  one-cycle start-of-frame pulse.
REQ-008 ROWSEL  in  4  front-buffer row to read.
REQ-009 ROWRED, ROWGRN  out  8  red/green bits of selected row, bit n = x n.
REQ-010 FRAMES  out  CNT_W  completed-swap count.
REQ-011 PIXCNT  out  7  accepted pixel words in last completed frame.
REQ-012 ERR  out  1  sticky: reserved-bit violation seen.
REQ-013 TMO  out  1  sticky: forced swap occurred.
REQ-014 BALLX out 3, BALLY out 4, BALLV out 1: last green pixel of front frame.

Function
REQ-015 Two 16x8x2-bit buffers, back (written) and front (read); role flag selects which is which.
REQ-016 Word accepted when STB=1, LEDIN[9:8]!=00, LEDIN[7]=0; sets bits (OR) at (y,x) in back buffer next cycle; no pixel is ever cleared by a write.
REQ-017 STB=1 with LEDIN[7]=1: word discarded, ERR set; colour 00 words discarded silently.
REQ-018 Swap on FRAME=1 or timeout counter reaching TIMEOUT-1: role flag toggles, new back buffer cleared in same cycle, FRAMES increments (wraps), PIXCNT loads live count, live count and timeout counter zero.
REQ-019 Forced swap sets TMO; FRAME and timeout coinciding count as one swap, TMO not set.
REQ-020 FRAME and accepted word in same cycle: word written into freshly cleared new back buffer and counted for the new frame.
REQ-021 Live pixel count saturates at 127.
REQ-022 ROWRED/ROWGRN registered: reflect ROWSEL of cycle N and front buffer after cycle-N updates, valid at cycle N+1 (latency 1); swap takes effect on read the cycle after swap.
REQ-023 FSM states IDLE (no FRAME seen since reset; words discarded, timeout stopped) and RUN (entered on first FRAME; never left except by RST).

Reset
REQ-024 RST: both buffers, ROWRED, ROWGRN, FRAMES, PIXCNT, ERR, TMO, BALLX, BALLY, BALLV, counters to 0; role flag 0; state IDLE.
REQ-025 RST mid-frame discards back-buffer contents; no swap counted.

Configuration
REQ-026 Macro LED_FRAME_DECODER_BALL_TRACK_EN defined: back-side tracker latches (x,y) of every accepted word with colour 01, valid flag set; on swap BALLX/BALLY/BALLV load tracker and tracker clears.
REQ-027 Macro undefined: tracker absent, BALLX/BALLY/BALLV constant 0; ports still present.

Structure
REQ-028 Package led_pkg: colour codes, LEDIN field positions, matrix dims 16x8, pixel-word struct.
REQ-029 Sub-module led_fb_bank: one 16x8x2 buffer with OR-write, one-cycle clear, row read; instantiated twice.

Verification
REQ-030 Reset, FRAME, STB words 10_0_1100_000/001/010, FRAME, ROWSEL=12 -> ROWRED=8'h07 next cycle, FRAMES=2, PIXCNT=3.
REQ-031 Word 01_0_0101_011 then FRAME -> ROWSEL=5 gives ROWGRN=8'h08; with macro BALLX=3, BALLY=5, BALLV=1; without macro all 0.
REQ-032 Word 10_1_0000_000 -> ERR=1, not written, PIXCNT excludes it.
REQ-033 TIMEOUT=16, FRAME once then none -> swap after 16 cycles, TMO=1, FRAMES increments each 16 cycles.
REQ-034 FRAME and word 11_0_0000_111 same cycle, next FRAME -> row 0 ROWRED=ROWGRN=8'h80, PIXCNT=1.
REQ-035 200 accepted words in one frame -> PIXCNT=127; RST mid-frame -> all outputs 0, state IDLE.
